// File: rtl/pulse_shaper_hs_param.sv
// Parametrised pulse-waveform generator. HI/LO lengths are fetched over a soc/eoc handshake and applied one period later.
// Optional build macro PULSE_SHAPER_HS_REPEAT_EN: with no new pair waiting, repeat the current HI/LO instead of stalling.
`timescale 1ns/1ps
module pulse_shaper_hs_param #(
  parameter int WIDTH      = 8,
  parameter int DEFAULT_HI = 5,
  parameter int DEFAULT_LO = 6
) (
  input  logic             clock,
  input  logic             reset,
  output logic             soc,
  input  logic             eoc,
  input  logic [WIDTH-1:0] numero,
  output logic             out,
  output logic             sync,
  output logic             pair_rdy
);

  typedef enum logic {
    GEN_LOW,
    GEN_HIGH
  } gen_state_e;

  typedef enum logic [2:0] {
    REQ_HI,
    WAIT_HI,
    REQ_LO,
    WAIT_LO,
    FULL
  } fetch_state_e;

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEF_HI = WIDTH'(DEFAULT_HI);
  localparam logic [WIDTH-1:0] DEF_LO = WIDTH'(DEFAULT_LO);

  // A converter result of zero would make a zero-length phase; store it as one.
  function automatic logic [WIDTH-1:0] clamp_len(input logic [WIDTH-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  // Generator state
  gen_state_e       gen_state_q, gen_state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             first_q, first_d;
  logic             out_q, out_d;
  logic             sync_q, sync_d;

  // Fetch state
  fetch_state_e     fetch_q, fetch_d;
  logic             soc_q, soc_d;
  logic [WIDTH-1:0] next_hi_q, next_hi_d;
  logic [WIDTH-1:0] next_lo_q, next_lo_d;
  logic             pair_rdy_q, pair_rdy_d;

  // Cross-process strobes
  logic             start;
  logic             apply_pair;
  logic [WIDTH-1:0] start_hi;

  // NOTE: every signal gets its hold value before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gen_state_d = gen_state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    first_d     = first_q;
    out_d       = out_q;
    sync_d      = 1'b0;
    start       = 1'b0;
    apply_pair  = 1'b0;
    start_hi    = hi_q;

    if (gen_state_q == GEN_HIGH) begin
      if (cnt_q == ONE) begin
        out_d       = 1'b0;
        cnt_d       = lo_q;
        gen_state_d = GEN_LOW;
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end else begin
      if (cnt_q != ONE) begin
        cnt_d = cnt_q - ONE;
      end else if (first_q) begin
        first_d = 1'b0;
        start   = 1'b1;
      end else if (pair_rdy_q) begin
        // pair_rdy is the registered value, so a pair completing on this very edge waits a period.
        apply_pair = 1'b1;
        hi_d       = next_hi_q;
        lo_d       = next_lo_q;
        start_hi   = next_hi_q;
        start      = 1'b1;
      end else begin
`ifdef PULSE_SHAPER_HS_REPEAT_EN
        start = 1'b1;
`else
        start = 1'b0;
`endif
      end
    end

    if (start) begin
      out_d       = 1'b1;
      cnt_d       = start_hi;
      sync_d      = 1'b1;
      gen_state_d = GEN_HIGH;
    end
  end

  always_comb begin
    fetch_d    = fetch_q;
    soc_d      = 1'b0;
    next_hi_d  = next_hi_q;
    next_lo_d  = next_lo_q;
    pair_rdy_d = pair_rdy_q;

    if (apply_pair) begin
      pair_rdy_d = 1'b0;
    end

    case (fetch_q)
      REQ_HI: begin
        if (!eoc) fetch_d = WAIT_HI;
        else      soc_d   = 1'b1;
      end
      WAIT_HI: begin
        if (eoc) begin
          next_hi_d = clamp_len(numero);
          fetch_d   = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!eoc) fetch_d = WAIT_LO;
        else      soc_d   = 1'b1;
      end
      WAIT_LO: begin
        if (eoc) begin
          next_lo_d  = clamp_len(numero);
          pair_rdy_d = 1'b1;
          fetch_d    = FULL;
        end
      end
      FULL: begin
        // Entering FULL sets pair_rdy on the same edge, so a low value here means it was consumed.
        if (!pair_rdy_q) fetch_d = REQ_HI;
      end
      default: fetch_d = REQ_HI;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      gen_state_q <= GEN_LOW;
      cnt_q       <= ONE;
      hi_q        <= DEF_HI;
      lo_q        <= DEF_LO;
      first_q     <= 1'b1;
      out_q       <= 1'b0;
      sync_q      <= 1'b0;
      fetch_q     <= REQ_HI;
      soc_q       <= 1'b0;
      next_hi_q   <= ONE;
      next_lo_q   <= ONE;
      pair_rdy_q  <= 1'b0;
    end else begin
      gen_state_q <= gen_state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      first_q     <= first_d;
      out_q       <= out_d;
      sync_q      <= sync_d;
      fetch_q     <= fetch_d;
      soc_q       <= soc_d;
      next_hi_q   <= next_hi_d;
      next_lo_q   <= next_lo_d;
      pair_rdy_q  <= pair_rdy_d;
    end
  end

  assign soc      = soc_q;
  assign out      = out_q;
  assign sync     = sync_q;
  assign pair_rdy = pair_rdy_q;

  a_cnt_nonzero: assert property (@(posedge clock) disable iff (reset) cnt_q != '0);
  a_sync_in_high: assert property (@(posedge clock) disable iff (reset) sync_q |-> out_q);
  a_soc_in_req: assert property (@(posedge clock) disable iff (reset)
    soc_q |-> (fetch_q == REQ_HI || fetch_q == REQ_LO));
  a_rdy_full: assert property (@(posedge clock) disable iff (reset) pair_rdy_q |-> fetch_q == FULL);

endmodule

// File: tb/tb_pulse_shaper_hs_param.sv
// Bench for pulse_shaper_hs_param: converter model feeds pairs into a scoreboard; an event-level period model predicts out/sync/pair_rdy.
`timescale 1ns/1ps
module tb_pulse_shaper_hs_param;

  localparam int DEF_HI = 5;
  localparam int DEF_LO = 6;

  logic       clock;
  logic       reset;
  logic       soc, eoc, out, sync, pair_rdy;
  logic [7:0] numero;
  logic       soc4, eoc4, out4, sync4, pair_rdy4;
  logic [3:0] numero4;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  pulse_shaper_hs_param #(.WIDTH(8), .DEFAULT_HI(DEF_HI), .DEFAULT_LO(DEF_LO)) u_dut (
    .clock(clock), .reset(reset), .soc(soc), .eoc(eoc), .numero(numero),
    .out(out), .sync(sync), .pair_rdy(pair_rdy)
  );

  pulse_shaper_hs_param #(.WIDTH(4), .DEFAULT_HI(DEF_HI), .DEFAULT_LO(DEF_LO)) u_dut4 (
    .clock(clock), .reset(reset), .soc(soc4), .eoc(eoc4), .numero(numero4),
    .out(out4), .sync(sync4), .pair_rdy(pair_rdy4)
  );

  typedef struct {
    int hi;
    int lo;
    int e;   // edge on which the pair becomes visible on pair_rdy
  } pair_t;

  int    cyc;
  int    n_checks = 0;
  int    n_pass   = 0;
  pair_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
  endtask

  function automatic int clamp1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  always @(posedge clock) begin
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  // Period model state
  bit m_first;
  int m_s, m_hi, m_lo;

  // Converter model state (main DUT)
  int conv_data[$];
  int conv_lat;
  int conv_cnt;
  bit conv_busy;
  bit conv_lo;
  int conv_val;
  int conv_hi_val;
  int conv_pairs;
  int align_pair;
  int align_wait;
  bit soc_seen;

  // WIDTH=4 instance: converter and edge recorder
  bit c4_busy;
  bit out4_prev;
  int epoch;
  int n_rise4, n_fall4;
  int rise4[3];
  int fall4[3];

  always @(negedge clock) begin : monitor
    bit    exp_sync, exp_out, exp_rdy, hold;
    pair_t p;
    if (reset) begin
      sb_q.delete();
      m_first   = 1'b1;
      m_s       = 0;
      m_hi      = 0;
      m_lo      = 0;
      conv_busy = 1'b0;
      conv_lo   = 1'b0;
      conv_pairs = 0;
      soc_seen  = 1'b0;
      eoc       = 1'b1;
      c4_busy   = 1'b0;
      eoc4      = 1'b1;
    end else begin
      if (soc) soc_seen = 1'b1;
      if (cyc >= 1) begin
        exp_sync = 1'b0;
        if (m_first) begin
          m_first  = 1'b0;
          m_s      = cyc;
          m_hi     = DEF_HI;
          m_lo     = DEF_LO;
          exp_sync = 1'b1;
        end else if (cyc >= m_s + m_hi + m_lo) begin
          if (sb_q.size() > 0 && sb_q[0].e <= cyc - 1) begin
            p        = sb_q.pop_front();
            m_hi     = p.hi;
            m_lo     = p.lo;
            m_s      = cyc;
            exp_sync = 1'b1;
          end
`ifdef PULSE_SHAPER_HS_REPEAT_EN
          else begin
            m_s      = cyc;
            exp_sync = 1'b1;
          end
`endif
        end
        exp_out = (cyc < m_s + m_hi);
        exp_rdy = (sb_q.size() > 0) && (sb_q[0].e <= cyc);
        check("out", out, exp_out);
        check("sync", sync, exp_sync);
        check("pair_rdy", pair_rdy, exp_rdy);
      end

      // Converter: eoc drops on a seen soc, rises with the result conv_lat cycles later.
      if (conv_busy) begin
        if (conv_cnt > 0) conv_cnt--;
        if (conv_cnt == 0) begin
          hold = conv_lo && (conv_pairs == align_pair) && (cyc + 1 != m_s + m_hi + m_lo);
          if (hold) begin
            align_wait++;
            if (align_wait > 100) begin
              check("align_timeout", align_wait, 0);
              hold = 1'b0;
            end
          end
          if (!hold) begin
            eoc    = 1'b1;
            numero = conv_val[7:0];
            if (conv_lo) begin
              sb_q.push_back('{clamp1(conv_hi_val), clamp1(conv_val), cyc + 1});
              conv_pairs++;
            end else begin
              conv_hi_val = conv_val;
            end
            conv_lo   = !conv_lo;
            conv_busy = 1'b0;
          end
        end
      end else if (soc && conv_data.size() > 0) begin
        conv_val   = conv_data.pop_front();
        conv_cnt   = conv_lat;
        conv_busy  = 1'b1;
        align_wait = 0;
        eoc        = 1'b0;
      end

      if (c4_busy) begin
        c4_busy = 1'b0;
        eoc4    = 1'b1;
        numero4 = 4'd15;
      end else if (soc4) begin
        c4_busy = 1'b1;
        eoc4    = 1'b0;
      end

      if (epoch == 0 && cyc >= 1) begin
        if (out4 && !out4_prev && n_rise4 < 3) begin
          rise4[n_rise4] = cyc;
          n_rise4++;
          check("w4_sync", sync4, 1);
        end
        if (!out4 && out4_prev && n_fall4 < 3) begin
          fall4[n_fall4] = cyc;
          n_fall4++;
        end
        out4_prev = out4;
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    conv_data.delete();
    align_pair = -1;
    @(negedge clock);
    check("rst_soc", soc, 0);
    check("rst_out", out, 0);
    check("rst_sync", sync, 0);
    check("rst_pair_rdy", pair_rdy, 0);
    check("rst_w4_soc", soc4, 0);
    check("rst_w4_out", out4, 0);
    check("rst_w4_pair_rdy", pair_rdy4, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    eoc        = 1'b1;
    numero     = '0;
    eoc4       = 1'b1;
    numero4    = '0;
    conv_lat   = 2;
    align_pair = -1;
    epoch      = 0;
    n_rise4    = 0;
    n_fall4    = 0;
    out4_prev  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rise4[i] = -1;
      fall4[i] = -1;
    end

    do_reset();
    // 3/2, zero pair, 8/8, then 4/3 whose LO lands on a period-start edge, then 2/3; queue then runs dry.
    conv_lat   = 2;
    conv_data  = '{3, 2, 0, 0, 8, 8, 4, 3, 2, 3};
    align_pair = 3;
    repeat (120) @(negedge clock);

    // Converter resumes after a stall.
    conv_data = '{2, 2};
    repeat (40) @(negedge clock);

    // Slow converter; reset while the LO conversion is outstanding.
    conv_lat  = 10;
    conv_data = '{6, 7};
    begin
      int w;
      w = 0;
      while (!(conv_busy && conv_lo) && w < 200) begin
        @(negedge clock);
        w++;
      end
    end
    check("wait_lo_reached", {31'd0, conv_busy && conv_lo}, 1);
    check("soc_pulsed", {31'd0, soc_seen}, 1);
    epoch = 1;
    do_reset();
    conv_lat  = 2;
    conv_data = '{3, 2};
    repeat (40) @(negedge clock);

    check("w4_rise0", rise4[0], 1);
    check("w4_hi0", fall4[0] - rise4[0], DEF_HI);
    check("w4_lo0", rise4[1] - fall4[0], DEF_LO);
    check("w4_hi1", fall4[1] - rise4[1], 15);
    check("w4_lo1", rise4[2] - fall4[1], 15);
    check("w4_hi2", fall4[2] - rise4[2], 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
